// File: rtl/thor2021_ir_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : thor2021_ir_sequencer                                        |
// | Description : Absorbs EXI prefix words from the fetch stream and presents  |
// |               {ir, xir, pc} triples to the decoder via one output register.|
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module thor2021_ir_sequencer #(
    parameter int          IW       = 48,
    parameter int          AW       = 32,
    parameter logic [7:0]  EXI7_OP  = 8'h50,
    parameter logic [7:0]  EXI23_OP = 8'h51,
    parameter logic [7:0]  EXI41_OP = 8'h52,
    parameter logic [7:0]  NOP_OP   = 8'hF1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          fch_valid_i,
    output logic          fch_ready_o,
    input  logic [IW-1:0] fch_ir_i,
    input  logic [AW-1:0] fch_pc_i,
    output logic          dec_valid_o,
    input  logic          dec_ready_i,
    output logic [IW-1:0] ir_o,
    output logic [IW-1:0] xir_o,
    output logic [AW-1:0] pc_o,
    output logic          pfx_pending_o,
    output logic          dbl_pfx_o
);

    localparam logic [0:0]    S_NOPFX    = 1'b0;
    localparam logic [0:0]    S_HELD     = 1'b1;
    localparam logic [IW-1:0] C_NOP_WORD = {{(IW-8){1'b0}}, NOP_OP};

    logic [0:0]    r_state,     w_state_nxt;
    logic [IW-1:0] r_pfx_word,  w_pfx_word_nxt;
    logic [AW-1:0] r_pfx_pc,    w_pfx_pc_nxt;
    logic          r_dec_valid, w_dec_valid_nxt;
    logic [IW-1:0] r_ir,        w_ir_nxt;
    logic [IW-1:0] r_xir,       w_xir_nxt;
    logic [AW-1:0] r_pc,        w_pc_nxt;
    logic          r_dbl,       w_dbl_nxt;

    logic          w_fch_ready;
    logic          w_accept;
    logic          w_is_pfx;

    assign w_fch_ready = ~flush_i & (~r_dec_valid | dec_ready_i);
    assign w_accept    = fch_valid_i & w_fch_ready;
    // Only the opcode byte identifies a prefix; upper bits are payload.
    assign w_is_pfx    = (fch_ir_i[7:0] == EXI7_OP) |
                         (fch_ir_i[7:0] == EXI23_OP) |
                         (fch_ir_i[7:0] == EXI41_OP);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_NOPFX;
            r_pfx_word  <= '0;
            r_pfx_pc    <= '0;
            r_dec_valid <= 1'b0;
            r_ir        <= C_NOP_WORD;
            r_xir       <= C_NOP_WORD;
            r_pc        <= '0;
            r_dbl       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pfx_word  <= w_pfx_word_nxt;
            r_pfx_pc    <= w_pfx_pc_nxt;
            r_dec_valid <= w_dec_valid_nxt;
            r_ir        <= w_ir_nxt;
            r_xir       <= w_xir_nxt;
            r_pc        <= w_pc_nxt;
            r_dbl       <= w_dbl_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pfx_word_nxt  = r_pfx_word;
        w_pfx_pc_nxt    = r_pfx_pc;
        w_dec_valid_nxt = r_dec_valid;
        w_ir_nxt        = r_ir;
        w_xir_nxt       = r_xir;
        w_pc_nxt        = r_pc;
        w_dbl_nxt       = 1'b0;

        if (flush_i) begin
            w_state_nxt     = S_NOPFX;
            w_pfx_word_nxt  = '0;
            w_pfx_pc_nxt    = '0;
            w_dec_valid_nxt = 1'b0;
        end else begin
            if (r_dec_valid & dec_ready_i) begin
                w_dec_valid_nxt = 1'b0;
            end
            if (w_accept) begin
                if (w_is_pfx) begin
                    w_dbl_nxt      = (r_state == S_HELD);
                    w_pfx_word_nxt = fch_ir_i;
                    w_pfx_pc_nxt   = fch_pc_i;
                    w_state_nxt    = S_HELD;
                end else begin
                    // A prefixed instruction restarts at the prefix address.
                    w_ir_nxt        = fch_ir_i;
                    w_xir_nxt       = (r_state == S_HELD) ? r_pfx_word : C_NOP_WORD;
                    w_pc_nxt        = (r_state == S_HELD) ? r_pfx_pc : fch_pc_i;
                    w_dec_valid_nxt = 1'b1;
                    w_state_nxt     = S_NOPFX;
                    w_pfx_word_nxt  = '0;
                    w_pfx_pc_nxt    = '0;
                end
            end
        end
    end

    assign fch_ready_o   = w_fch_ready;
    assign dec_valid_o   = r_dec_valid;
    assign ir_o          = r_ir;
    assign xir_o         = r_xir;
    assign pc_o          = r_pc;
    assign pfx_pending_o = (r_state == S_HELD);
    assign dbl_pfx_o     = r_dbl;

endmodule
`default_nettype wire
